// File: rtl/spi_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// SpiFrameSequencerIf
// Purpose : groups the command, counter and SPI-side signals of the SPI frame
//           sequencer into one bundle so the controller and its surroundings
//           connect through a single port.
// Signals :
//   start      command layer -> sequencer, one-cycle frame request
//   nbits      command layer -> sequencer, bits per frame (0 = ignore request)
//   cuenta     external counter -> sequencer, current count value
//   cnt_en     sequencer -> external counter, count enable
//   cnt_clr    sequencer -> external counter, clear
//   cs_n       SPI chip select, active-low
//   sclk       SPI clock, mode 0
//   sample_en  pulse on each sclk rising edge
//   shift_en   pulse on each sclk falling edge
//   busy       frame in progress (start accepted until gap completes)
//   done       pulse when the hold phase completes
// Modports: slave = the sequencer itself, master = everything around it.
// ---------------------------------------------------------------------------
interface spi_frame_sequencer_if #(
    parameter int CNT_W = 12
);
    logic             start;
    logic [5:0]       nbits;
    logic [CNT_W-1:0] cuenta;
    logic             cnt_en;
    logic             cnt_clr;
    logic             cs_n;
    logic             sclk;
    logic             sample_en;
    logic             shift_en;
    logic             busy;
    logic             done;

    modport slave (
        input  start, nbits, cuenta,
        output cnt_en, cnt_clr, cs_n, sclk, sample_en, shift_en, busy, done
    );

    modport master (
        output start, nbits, cuenta,
        input  cnt_en, cnt_clr, cs_n, sclk, sample_en, shift_en, busy, done
    );
endinterface

// File: rtl/spi_frame_sequencer.sv
// ---------------------------------------------------------------------------
// spi_frame_sequencer
// Purpose : sequences one SPI master frame (chip-select setup, nbits sclk
//           periods, hold, inter-frame gap). Every phase is timed by a shared
//           external up-counter that this block clears and enables, and whose
//           value it compares against the current phase limit.
// Ports   :
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   spi_frame_sequencer_if.slave (start, nbits, cuenta in;
//         cnt_en, cnt_clr, cs_n, sclk, sample_en, shift_en, busy, done out)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module spi_frame_sequencer #(
    parameter int CNT_W     = 12,
    parameter int SETUP_CYC = 4,
    parameter int HALF_PER  = 3,
    parameter int HOLD_CYC  = 4,
    parameter int GAP_CYC   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_frame_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LIM = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LIM  = CNT_W'(HALF_PER - 1);
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_CYC - 1);

    state_t           r_state;
    logic [5:0]       r_nbits;
    logic [6:0]       r_edgeCnt;
    logic             r_cntEn;
    logic             r_cntClr;
    logic             r_csN;
    logic             r_sclk;
    logic             r_sampleEn;
    logic             r_shiftEn;
    logic             r_busy;
    logic             r_done;

    logic [CNT_W-1:0] w_limit;
    logic             w_phaseEnd;
    logic             w_lastToggle;

    // Terminal count of the phase currently running. The compare is >= so a
    // counter that somehow overshoots still ends the phase instead of waiting
    // for a wrap-around.
    always_comb begin
        w_limit = '0;
        case (r_state)
            SETUP:   w_limit = SETUP_LIM;
            SHIFT:   w_limit = HALF_LIM;
            HOLD:    w_limit = HOLD_LIM;
            GAP:     w_limit = GAP_LIM;
            default: w_limit = '0;
        endcase
    end

    assign w_phaseEnd   = r_cntEn && (bus.cuenta >= w_limit);
    assign w_lastToggle = (r_edgeCnt == ({r_nbits, 1'b0} - 7'd1));

    // Frame controller. Every phase opens with one clear cycle (cnt_clr high,
    // cnt_en low), then counts until the phase limit is reached. The edge
    // that ends a phase also raises cnt_clr again, which doubles as the clear
    // cycle of the following phase. In SHIFT each half-period end toggles
    // sclk and emits the matching sample/shift pulse; after 2*nbits toggles
    // the line is back low and the frame moves to HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_nbits    <= '0;
            r_edgeCnt  <= '0;
            r_cntEn    <= 1'b0;
            r_cntClr   <= 1'b1;
            r_csN      <= 1'b1;
            r_sclk     <= 1'b0;
            r_sampleEn <= 1'b0;
            r_shiftEn  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sampleEn <= 1'b0;
            r_shiftEn  <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cntClr <= 1'b1;
                    r_cntEn  <= 1'b0;
                    if (bus.start && (bus.nbits != 6'd0)) begin
                        r_nbits   <= bus.nbits;
                        r_edgeCnt <= '0;
                        r_csN     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                default: begin
                    if (r_cntClr) begin
                        r_cntClr <= 1'b0;
                        r_cntEn  <= 1'b1;
                    end else if (w_phaseEnd) begin
                        r_cntClr <= 1'b1;
                        r_cntEn  <= 1'b0;
                        case (r_state)
                            SETUP: begin
                                r_state <= SHIFT;
                            end
                            SHIFT: begin
                                r_sclk    <= ~r_sclk;
                                r_edgeCnt <= r_edgeCnt + 7'd1;
                                if (!r_sclk) begin
                                    r_sampleEn <= 1'b1;
                                end else begin
                                    r_shiftEn <= 1'b1;
                                end
                                if (w_lastToggle) begin
                                    r_state <= HOLD;
                                end
                            end
                            HOLD: begin
                                r_csN   <= 1'b1;
                                r_done  <= 1'b1;
                                r_state <= GAP;
                            end
                            GAP: begin
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                            default: begin
                                r_state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.cnt_en    = r_cntEn;
    assign bus.cnt_clr   = r_cntClr;
    assign bus.cs_n      = r_csN;
    assign bus.sclk      = r_sclk;
    assign bus.sample_en = r_sampleEn;
    assign bus.shift_en  = r_shiftEn;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
